// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_pkg
//  Description : Shared WS2812 constants: word width, FSM encoding and the
//                nanosecond-to-clock-count helper used by the RX and TX.
//  Revision    : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

    localparam int c_WORD_W = 24;

    localparam logic [1:0] c_ST_SYNC = 2'd0;
    localparam logic [1:0] c_ST_LOW  = 2'd1;
    localparam logic [1:0] c_ST_HIGH = 2'd2;

    // Rounds up so a threshold is never shorter than the nominal time.
    function automatic int ns_to_cycles(input int clk_mhz, input int ns);
        return (clk_mhz * ns + 999) / 1000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_sync
//  Description : Two-flop synchronizer with asynchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/ws2812_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_rx
//  Description : WS2812 serial receiver; decodes pulse widths into 24-bit
//                words with per-frame LED indexing and error strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS    = 8,
    parameter int CLK_MHZ     = 12,
    parameter int T_THRESH    = ns_to_cycles(CLK_MHZ, 625),
    parameter int T_MIN       = ns_to_cycles(CLK_MHZ, 150),
    parameter int T_MAX       = ns_to_cycles(CLK_MHZ, 2000),
    parameter int T_RESET_DET = ns_to_cycles(CLK_MHZ, 50000)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                din,
    output logic [c_WORD_W-1:0] rgb_data,
    output logic [7:0]          led_num,
    output logic                valid,
    output logic                frame_done,
    output logic                error,
    output logic                overflow
);

    localparam int CNT_W = $clog2(T_RESET_DET + 1);

    localparam logic [CNT_W-1:0] c_reset_det  = CNT_W'(T_RESET_DET);
    localparam logic [CNT_W-1:0] c_reset_last = CNT_W'(T_RESET_DET - 1);
    localparam logic [CNT_W-1:0] c_thresh     = CNT_W'(T_THRESH);
    localparam logic [CNT_W-1:0] c_min        = CNT_W'(T_MIN);
    localparam logic [CNT_W-1:0] c_max_last   = CNT_W'(T_MAX - 1);
    localparam logic [4:0]       c_bit_last   = 5'(c_WORD_W - 1);
    localparam logic [8:0]       c_num_leds   = 9'((NUM_LEDS > 256) ? 256 : NUM_LEDS);

    logic                w_s;
    logic                w_bit;
    logic [c_WORD_W-1:0] w_next_word;
    logic                w_word_ok;

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_low_cnt;
    logic [CNT_W-1:0]    r_high_cnt;
    logic [4:0]          r_bit_cnt;
    logic [7:0]          r_word_cnt;
    logic [c_WORD_W-1:0] r_shift;
    logic [c_WORD_W-1:0] r_rgb_data;
    logic [7:0]          r_led_num;
    logic                r_valid;
    logic                r_frame_done;
    logic                r_error;
    logic                r_overflow;

    ws2812_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (din),
        .o_q     (w_s)
    );

    assign w_bit       = (r_high_cnt >= c_thresh);
    assign w_next_word = {r_shift[c_WORD_W-2:0], w_bit};
    assign w_word_ok   = ({1'b0, r_word_cnt} < c_num_leds);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_ST_SYNC;
            r_low_cnt    <= '0;
            r_high_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_word_cnt   <= '0;
            r_shift      <= '0;
            r_rgb_data   <= '0;
            r_led_num    <= '0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_error      <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_error      <= 1'b0;
            r_overflow   <= 1'b0;
            case (r_state)
                c_ST_SYNC: begin
                    if (w_s) begin
                        r_low_cnt <= '0;
                    end else if (r_low_cnt == c_reset_last) begin
                        // Already a full reset gap, so park the low counter saturated.
                        r_state    <= c_ST_LOW;
                        r_low_cnt  <= c_reset_det;
                        r_bit_cnt  <= '0;
                        r_word_cnt <= '0;
                    end else begin
                        r_low_cnt <= r_low_cnt + 1'b1;
                    end
                end
                c_ST_LOW: begin
                    if (w_s) begin
                        r_state    <= c_ST_HIGH;
                        r_high_cnt <= CNT_W'(1);
                    end else if (r_low_cnt != c_reset_det) begin
                        r_low_cnt <= r_low_cnt + 1'b1;
                        if (r_low_cnt == c_reset_last) begin
                            r_frame_done <= (r_word_cnt != 8'd0);
                            r_error      <= (r_bit_cnt != 5'd0);
                            r_bit_cnt    <= '0;
                            r_word_cnt   <= '0;
                        end
                    end
                end
                c_ST_HIGH: begin
                    if (w_s) begin
                        if (r_high_cnt >= c_max_last) begin
                            r_error   <= 1'b1;
                            r_state   <= c_ST_SYNC;
                            r_low_cnt <= '0;
                        end else begin
                            r_high_cnt <= r_high_cnt + 1'b1;
                        end
                    end else if (r_high_cnt < c_min) begin
                        r_error   <= 1'b1;
                        r_state   <= c_ST_SYNC;
                        r_low_cnt <= '0;
                    end else begin
                        r_shift   <= w_next_word;
                        r_low_cnt <= CNT_W'(1);
                        r_state   <= c_ST_LOW;
                        if (r_bit_cnt == c_bit_last) begin
                            r_bit_cnt <= '0;
                            if (w_word_ok) begin
                                r_rgb_data <= w_next_word;
                                r_led_num  <= r_word_cnt;
                                r_valid    <= 1'b1;
                            end else begin
                                r_overflow <= 1'b1;
                            end
                            if (r_word_cnt != 8'hFF) begin
                                r_word_cnt <= r_word_cnt + 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= c_ST_SYNC;
                    r_low_cnt <= '0;
                end
            endcase
        end
    end

    assign rgb_data   = r_rgb_data;
    assign led_num    = r_led_num;
    assign valid      = r_valid;
    assign frame_done = r_frame_done;
    assign error      = r_error;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire
